// File: rtl/fpga_rstseq_pkg.sv
// Shared types and constants for the board reset/boot sequencer.
// State encodings are fixed because state_o drives board LEDs and debug headers.
package fpga_rstseq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        DEBOUNCE  = 3'd1,
        SOC_HOLD  = 3'd2,
        RUN       = 3'd3
    } rstseq_state_e;

    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = WAIT_LOCK;
    localparam logic [STATE_W-1:0] ST_DEBOUNCE  = DEBOUNCE;
    localparam logic [STATE_W-1:0] ST_SOC_HOLD  = SOC_HOLD;
    localparam logic [STATE_W-1:0] ST_RUN       = RUN;

    // Counter width able to hold max_val without ever wrapping.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/fpga_rstseq_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous board input.
// Latency SYNC_STAGES cycles; reset forces the output low.
module fpga_rstseq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fpga_reset_sequencer.sv
// Board reset/boot sequencer: sync + debounce button and PLL lock, hold SoC in reset, latch bootsel.
// Optional status LED (led_o, blink counter) enabled by defining PULP_FPGA_RSTSEQ_LED_EN.
module fpga_reset_sequencer
    import fpga_rstseq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 64,
    parameter int LOCK_TIMEOUT    = 10000000,
    parameter int BLINK_BIT       = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pad_reset_n_i,
    input  logic               clk_locked_i,
    input  logic               bootsel_i,
    output logic               soc_rst_no,
    output logic               bootsel_o,
    output logic [STATE_W-1:0] state_o,
    output logic               timeout_o
`ifdef PULP_FPGA_RSTSEQ_LED_EN
    ,
    output logic               led_o
`endif
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int TMO_W   = cnt_width(LOCK_TIMEOUT);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 ||
        LOCK_TIMEOUT < 1 || BLINK_BIT < 0) begin : g_param_chk
        $error("fpga_reset_sequencer: illegal parameter value");
    end

    logic btn_s, lock_s, boot_s;

    fpga_rstseq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
        .clk(clk), .reset(reset), .d(pad_reset_n_i), .q(btn_s)
    );
    fpga_rstseq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
        .clk(clk), .reset(reset), .d(clk_locked_i), .q(lock_s)
    );
    fpga_rstseq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_boot (
        .clk(clk), .reset(reset), .d(bootsel_i), .q(boot_s)
    );

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               timeout_q, timeout_d;
    logic               bootsel_q, bootsel_d;
    logic               rst_n_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_cnt_d = '0;
        timeout_d = timeout_q;
        bootsel_d = bootsel_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (btn_s && lock_s) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end else begin
                    tmo_cnt_d = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
                    if (tmo_cnt_q == TMO_LAST) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (!btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    // bootsel is sampled on the same edge the inputs are declared stable
                    state_d   = ST_SOC_HOLD;
                    cnt_d     = '0;
                    bootsel_d = boot_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SOC_HOLD: begin
                if (!btn_s || !lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!btn_s || !lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
            bootsel_q <= 1'b0;
            rst_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
            bootsel_q <= bootsel_d;
            rst_n_q   <= (state_d == ST_RUN);
        end
    end

    assign soc_rst_no = rst_n_q;
    assign bootsel_o  = bootsel_q;
    assign state_o    = state_q;
    assign timeout_o  = timeout_q;

`ifdef PULP_FPGA_RSTSEQ_LED_EN
    logic [BLINK_BIT:0] blink_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + 1'b1;
        end
    end

    assign led_o = (state_q == ST_RUN) ? 1'b1 :
                   timeout_q           ? 1'b0 : blink_q[BLINK_BIT];
`endif

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Scoreboard bench for fpga_reset_sequencer: expected release cycle/bootsel queued at stimulus time.
module tb_fpga_reset_sequencer;

    localparam int SYNC    = 2;
    localparam int DEB     = 8;
    localparam int HOLD    = 4;
    localparam int TMO     = 32;
    localparam int BLINK   = 3;
    // input change at negedge -> soc_rst_no rising edge, clean case
    localparam int REL_LAT = SYNC + 1 + DEB + HOLD;

    logic       clk = 1'b0;
    logic       reset;
    logic       pad;
    logic       lock;
    logic       boot;
    logic       soc_rst_no;
    logic       bootsel_o;
    logic [2:0] state_o;
    logic       timeout_o;
`ifdef PULP_FPGA_RSTSEQ_LED_EN
    logic       led;
`endif

    fpga_reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .LOCK_TIMEOUT   (TMO),
        .BLINK_BIT      (BLINK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pad_reset_n_i(pad),
        .clk_locked_i (lock),
        .bootsel_i    (boot),
        .soc_rst_no   (soc_rst_no),
        .bootsel_o    (bootsel_o),
        .state_o      (state_o),
        .timeout_o    (timeout_o)
`ifdef PULP_FPGA_RSTSEQ_LED_EN
        ,
        .led_o        (led)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic boot;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every rising edge of soc_rst_no must match a queued expectation.
    logic rst_prev = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (soc_rst_no === 1'b1 && rst_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_release", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("release_cycle", cyc, mon_e.cyc);
                check("release_bootsel", {31'd0, bootsel_o}, {31'd0, mon_e.boot});
            end
        end
        rst_prev = soc_rst_no;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_release(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("release_seen", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1;
        pad   = 1'b1;
        lock  = 1'b1;
        boot  = 1'b1;

        // Reset values, then clean release with bootsel changing in SOC_HOLD
        step(3);
        check("rst_soc_rst_no", {31'd0, soc_rst_no}, 0);
        check("rst_bootsel", {31'd0, bootsel_o}, 0);
        check("rst_state", {29'd0, state_o}, 0);
        check("rst_timeout", {31'd0, timeout_o}, 0);
`ifdef PULP_FPGA_RSTSEQ_LED_EN
        check("rst_led", {31'd0, led}, 0);
`endif
        reset = 1'b0;
        t = cyc;
        sb_q.push_back('{t + REL_LAT, 1'b1});
        step(4);
        check("clean_debounce_state", {29'd0, state_o}, 1);
        step(8);
        check("clean_hold_state", {29'd0, state_o}, 2);
        boot = 1'b0;
        wait_release(40);
        step(3);
        check("run_state", {29'd0, state_o}, 3);
        check("run_bootsel_held", {31'd0, bootsel_o}, 1);
`ifdef PULP_FPGA_RSTSEQ_LED_EN
        check("run_led", {31'd0, led}, 1);
`endif

        // Lock loss in RUN, then full sequence again with bootsel now low
        lock = 1'b0;
        step(SYNC);
        check("lockdrop_still_run", {31'd0, soc_rst_no}, 1);
        step(1);
        check("lockdrop_soc_rst_no", {31'd0, soc_rst_no}, 0);
        check("lockdrop_state", {29'd0, state_o}, 0);
        step(3);
        lock = 1'b1;
        t = cyc;
        sb_q.push_back('{t + REL_LAT, 1'b0});
        wait_release(40);

        // Button press in RUN, then a one-cycle glitch at debounce count 5
        boot = 1'b1;
        pad  = 1'b0;
        step(SYNC + 1);
        check("btn_soc_rst_no", {31'd0, soc_rst_no}, 0);
        check("btn_state", {29'd0, state_o}, 0);
        step(2);
        pad = 1'b1;
        t = cyc;
        sb_q.push_back('{t + REL_LAT + 6, 1'b1});
        step(6);
        pad = 1'b0;
        step(1);
        pad = 1'b1;
        step(8);
        check("glitch_delayed", {31'd0, soc_rst_no}, 0);
        wait_release(40);

        // Reset while in RUN, then lock held low until timeout
        step(2);
        reset = 1'b1;
        lock  = 1'b0;
        step(1);
        check("run_reset_soc_rst_no", {31'd0, soc_rst_no}, 0);
        check("run_reset_bootsel", {31'd0, bootsel_o}, 0);
        check("run_reset_state", {29'd0, state_o}, 0);
        step(2);
        reset = 1'b0;
        step(TMO - 1);
        check("timeout_not_yet", {31'd0, timeout_o}, 0);
        step(1);
        check("timeout_set", {31'd0, timeout_o}, 1);
`ifdef PULP_FPGA_RSTSEQ_LED_EN
        check("timeout_led", {31'd0, led}, 0);
`endif
        step(10);
        lock = 1'b1;
        t = cyc;
        sb_q.push_back('{t + REL_LAT, 1'b1});
        wait_release(40);
        check("timeout_sticky", {31'd0, timeout_o}, 1);

        // Illegal state encoding recovers to WAIT_LOCK and restarts the sequence
        step(2);
        force dut.state_q = 3'd5;
        #1;
        check("illegal_visible", {29'd0, state_o}, 5);
        release dut.state_q;
        t = cyc;
        sb_q.push_back('{t + 2 + DEB + HOLD, 1'b1});
        step(1);
        check("illegal_state", {29'd0, state_o}, 0);
        check("illegal_soc_rst_no", {31'd0, soc_rst_no}, 0);
        wait_release(40);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
